// File: rtl/coder_pkg.sv
// Shared types for the coder pipeline: mode encoding and skid-buffer occupancy states.
package coder_pkg;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_ENCODE = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } coder_state_e;

endpackage

// File: rtl/coder_if.sv
// Input/output stream bundle of the coder pipeline, sized from the binary field width.
interface coder_if #(
  parameter int IN_W = 4
) ();
  localparam int OUT_W = 2**IN_W;

  // Both sides: a beat transfers on a rising edge where valid and ready are both 1;
  // a producer holds valid and its payload stable until that edge.
  logic             enable;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_none;

  modport master (
    output enable, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_none
  );

  modport slave (
    input  enable, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_none
  );

endinterface

// File: rtl/coder_core.sv
// Combinational datapath: binary-to-one-hot decode or MSB-priority encode, gated by enable.
module coder_core
  import coder_pkg::*;
#(
  parameter  int IN_W  = 4,
  localparam int OUT_W = 2**IN_W
) (
  input  logic [OUT_W-1:0] in_data,
  input  logic             enable,
  input  logic             mode,
  output logic [OUT_W-1:0] result,
  output logic             none
);

  logic [IN_W-1:0] idx;
  logic            hit;

  always_comb begin
    result = '0;
    none   = 1'b0;
    idx    = '0;
    hit    = 1'b0;
    // Ascending scan: the last set bit seen is the most significant one.
    for (int i = 0; i < OUT_W; i++) begin
      if (in_data[i]) begin
        idx = IN_W'(i);
        hit = 1'b1;
      end
    end
    if (!enable) begin
      none = 1'b1;
    end else if (mode == MODE_DECODE) begin
      result[in_data[IN_W-1:0]] = 1'b1;
    end else begin
      result[IN_W-1:0] = idx;
      none             = !hit;
    end
  end

endmodule

// File: rtl/coder_pipe.sv
// One-cycle coder stage behind a 2-entry skid buffer; in_ready is registered and
// never looks at out_ready, so the skid entry absorbs a stalled downstream.
module coder_pipe
  import coder_pkg::*;
#(
  parameter  int IN_W  = 4,
  localparam int OUT_W = 2**IN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  coder_if.slave       bus,
  output coder_state_e state_o
);

  logic [OUT_W-1:0] core_result;
  logic             core_none;

  coder_core #(.IN_W(IN_W)) u_core (
    .in_data (bus.in_data),
    .enable  (bus.enable),
    .mode    (bus.mode),
    .result  (core_result),
    .none    (core_none)
  );

  coder_state_e     state_q,     state_d;
  logic             in_ready_q,  in_ready_d;
  logic [OUT_W-1:0] main_data_q, main_data_d;
  logic             main_none_q, main_none_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic             skid_none_q, skid_none_d;

  logic accept;
  logic drain;

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = (state_q != EMPTY) && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_none_d = main_none_q;
    skid_data_d = skid_data_q;
    skid_none_d = skid_none_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_data_d = core_result;
          main_none_d = core_none;
          state_d     = ONE;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          skid_data_d = core_result;
          skid_none_d = core_none;
          state_d     = TWO;
        end else if (accept && drain) begin
          main_data_d = core_result;
          main_none_d = core_none;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (drain) begin
          main_data_d = skid_data_q;
          main_none_d = skid_none_q;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      main_data_q <= '0;
      main_none_q <= 1'b0;
      skid_data_q <= '0;
      skid_none_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_none_q <= main_none_d;
      skid_data_q <= skid_data_d;
      skid_none_q <= skid_none_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = main_data_q;
  assign bus.out_none  = main_none_q;
  assign state_o       = state_q;

endmodule
